// File: rtl/lsu_mem_req.sv
// rtl/lsu_mem_req.sv - load/store unit data-memory request initiator (optional LSU_DELAY_EN: multi-cycle access of MEM_LAT cycles)
module lsu_mem_req #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_is_load,
  output logic        out_err,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_wdith,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic        load_q;
  logic        req;
  logic        req_err;
  logic        bad_op;
  logic        misaligned;
  logic        last;
  logic [31:0] req_width;
  logic [31:0] ext_data;

  // A new request can be taken when idle, or when the pending response is being consumed.
  assign in_ready  = (state == S_IDLE) | ((state == S_RESP) & out_ready);
  assign out_valid = (state == S_RESP);
  assign req       = in_valid & in_ready & (in_load | in_store);

  // Classify the incoming request: illegal op first, then alignment against the access size.
  always_comb begin
    bad_op     = 1'b0;
    misaligned = 1'b0;
    req_width  = 32'd4;
    case (in_op)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_op = in_store & ~in_load & in_op[2];
      default:                                bad_op = 1'b1;
    endcase
    case (in_op[1:0])
      2'b00:   req_width = 32'd1;
      2'b01: begin
        req_width  = 32'd2;
        misaligned = in_addr[0];
      end
      default: begin
        req_width  = 32'd4;
        misaligned = |in_addr[1:0];
      end
    endcase
  end

  assign req_err = bad_op | misaligned;

`ifdef LSU_DELAY_EN
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  logic [CW-1:0] cnt;

  // Down-counter holding ACCESS for MEM_LAT cycles; zero marks the final access cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (req) begin
      cnt <= CW'(MEM_LAT - 1);
    end else if ((state == S_ACCESS) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);
`else
  // Single-cycle access; MEM_LAT has no effect without the delay option.
  assign last = (MEM_LAT > 0) | 1'b1;
`endif

  // Strobes live only in ACCESS; a store writes once, on the final access cycle.
  assign mem_re = (state == S_ACCESS) & load_q;
  assign mem_we = (state == S_ACCESS) & ~load_q & last;

  // Sign/zero extension of the returned low bytes according to the latched op.
  always_comb begin
    ext_data = mem_dout;
    case (op_q)
      3'b000:  ext_data = {{24{mem_dout[7]}}, mem_dout[7:0]};
      3'b100:  ext_data = {24'd0, mem_dout[7:0]};
      3'b001:  ext_data = {{16{mem_dout[15]}}, mem_dout[15:0]};
      3'b101:  ext_data = {16'd0, mem_dout[15:0]};
      default: ext_data = mem_dout;
    endcase
  end

  // Request/response FSM; errored requests bypass ACCESS so memory never sees them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= 3'd0;
      load_q      <= 1'b0;
      out_rdata   <= 32'd0;
      out_rd      <= 5'd0;
      out_is_load <= 1'b0;
      out_err     <= 1'b0;
      mem_wdith   <= 32'd0;
      mem_addr    <= 32'd0;
      mem_din     <= 32'd0;
    end else if (req) begin
      op_q        <= in_op;
      load_q      <= in_load;
      mem_addr    <= in_addr;
      mem_din     <= in_wdata;
      mem_wdith   <= req_width;
      out_rd      <= in_rd;
      out_is_load <= in_load;
      out_rdata   <= 32'd0;
      out_err     <= req_err;
      state       <= req_err ? S_RESP : S_ACCESS;
    end else if ((state == S_RESP) && out_ready) begin
      state <= S_IDLE;
    end else if ((state == S_ACCESS) && last) begin
      state     <= S_RESP;
      out_rdata <= load_q ? ext_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_req.sv
// tb/tb_lsu_mem_req.sv - scoreboard bench for lsu_mem_req (define LSU_DELAY_EN to exercise MEM_LAT=3)
module tb_lsu_mem_req;

`ifdef LSU_DELAY_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_store;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_is_load;
  logic        out_err;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_wdith;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  lsu_mem_req #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_op(in_op), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_is_load(out_is_load), .out_err(out_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdith(mem_wdith), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        is_load;
    logic        err;
    logic [31:0] width;
    logic [31:0] addr;
    logic [31:0] din;
    int          re_n;
    int          we_n;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] mem_rd_data;

  assign mem_dout = mem_rd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic ld, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] dout);
    exp_t e;
    logic legal;
    int   size;
    legal = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd5);
    if (!ld && op >= 3'd4) legal = 1'b0;
    size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    e.err     = !legal || ((addr % size) != 0);
    e.is_load = ld;
    e.rd      = rd;
    e.width   = size;
    e.addr    = addr;
    e.din     = wdata;
    e.rdata   = 32'd0;
    if (!e.err && ld) begin
      if (op == 3'd0)      e.rdata = dout[7] ? (32'hFFFFFF00 | dout[7:0]) : {24'd0, dout[7:0]};
      else if (op == 3'd4) e.rdata = dout & 32'h000000FF;
      else if (op == 3'd1) e.rdata = dout[15] ? (32'hFFFF0000 | dout[15:0]) : {16'd0, dout[15:0]};
      else if (op == 3'd5) e.rdata = dout & 32'h0000FFFF;
      else                 e.rdata = dout;
    end
    e.lat  = e.err ? 1 : LAT + 1;
    e.re_n = (!e.err && ld) ? LAT : 0;
    e.we_n = (!e.err && !ld) ? 1 : 0;
    return e;
  endfunction

  // Monitor: strobe checks, latency, and response comparison against the scoreboard front.
  initial begin
    int re_cnt = 0;
    int we_cnt = 0;
    int acc_cyc = 0;
    bit seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        re_cnt = 0;
        we_cnt = 0;
        seen = 0;
      end else begin
        check("strobe_excl", {31'd0, mem_re & mem_we}, 32'd0);
        if (mem_re || mem_we) begin
          if (sb.size() == 0) begin
            check("strobe_no_req", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            check("mem_wdith", mem_wdith, e.width);
            check("mem_addr", mem_addr, e.addr);
            if (mem_we) check("mem_din", mem_din, e.din);
            if (mem_re) re_cnt++;
            if (mem_we) we_cnt++;
          end
        end
        if (out_valid && !seen && sb.size() != 0) begin
          seen = 1;
          check("latency", cyc - acc_cyc, sb[0].lat);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("resp_no_req", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("out_rdata", out_rdata, e.rdata);
            check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            check("out_is_load", {31'd0, out_is_load}, {31'd0, e.is_load});
            check("out_err", {31'd0, out_err}, {31'd0, e.err});
            check("re_cycles", re_cnt, e.re_n);
            check("we_cycles", we_cnt, e.we_n);
          end
          re_cnt = 0;
          we_cnt = 0;
          seen = 0;
        end
        if (in_valid && in_ready && (in_load || in_store)) acc_cyc = cyc;
      end
    end
  end

  task automatic send(input logic ld, input logic st, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] dout);
    int n = 0;
    sb.push_back(model(ld, op, addr, wdata, rd, dout));
    mem_rd_data = dout;
    in_load  = ld;
    in_store = st;
    in_op    = op;
    in_addr  = addr;
    in_wdata = wdata;
    in_rd    = rd;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_load  = 1'b0;
    in_store = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    check({tag, "_out_rdata"}, out_rdata, 32'd0);
    check({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
    check({tag, "_out_is_load"}, {31'd0, out_is_load}, 32'd0);
    check({tag, "_out_err"}, {31'd0, out_err}, 32'd0);
    check({tag, "_mem_wdith"}, mem_wdith, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_din"}, mem_din, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ops[5];
    logic [31:0] hold;
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_op = 3'd0;
    in_addr = 32'd0; in_wdata = 32'd0; in_rd = 5'd0;
    out_ready = 1'b1;
    mem_rd_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(1, 0, 3'b010, 32'h80000010, 32'h0, 5'd3, 32'hDEADBEEF); drain();
    send(1, 0, 3'b000, 32'h80000020, 32'h0, 5'd4, 32'h000080F0); drain();
    send(1, 0, 3'b100, 32'h80000021, 32'h0, 5'd5, 32'h000080F0); drain();
    send(1, 0, 3'b001, 32'h80000022, 32'h0, 5'd6, 32'h000080F0); drain();
    send(1, 0, 3'b101, 32'h80000024, 32'h0, 5'd7, 32'h000080F0); drain();
    send(0, 1, 3'b001, 32'h80000002, 32'h1234ABCD, 5'd8, 32'hFFFFFFFF); drain();
    send(0, 1, 3'b010, 32'h80000008, 32'hCAFEF00D, 5'd9, 32'h0); drain();
    send(1, 0, 3'b010, 32'h80000001, 32'h0, 5'd10, 32'h11111111); drain();
    send(1, 0, 3'b011, 32'h80000000, 32'h0, 5'd11, 32'h11111111); drain();
    send(1, 0, 3'b101, 32'h80000003, 32'h0, 5'd12, 32'h11111111); drain();
    send(0, 1, 3'b100, 32'h80000000, 32'h55, 5'd13, 32'h0); drain();
    send(1, 1, 3'b000, 32'h80000033, 32'h0, 5'd14, 32'h0000007F); drain();

    // A valid beat carrying neither load nor store must be ignored.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("ignored_out_valid", {31'd0, out_valid}, 32'd0);
      check("ignored_in_ready", {31'd0, in_ready}, 32'd1);
      check("ignored_strobe", {31'd0, mem_re | mem_we}, 32'd0);
    end
    in_valid = 1'b0;

    // Backpressure, then a handshake-cycle accept of the next request.
    out_ready = 1'b0;
    send(1, 0, 3'b010, 32'h80000040, 32'h0, 5'd15, 32'hA5A5C3C3);
    repeat (LAT) @(posedge clk);
    #1;
    hold = 32'hA5A5C3C3;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_rdata", out_rdata, hold);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_same_cycle_ready", {31'd0, in_ready}, 32'd1);
    send(1, 0, 3'b001, 32'h80000046, 32'h0, 5'd16, 32'h00007001);
    drain();

    // Reset while a store is in ACCESS.
    send(0, 1, 3'b010, 32'h80000050, 32'h87654321, 5'd17, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("rst_mid");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_we", {31'd0, mem_we}, 32'd0);
    end

    for (int i = 0; i < 20; i++) begin
      logic ld;
      logic [2:0] op;
      ld = 1'($urandom_range(0, 1));
      op = ops[$urandom_range(0, 4)];
      send(ld, ~ld, op, {$urandom} & 32'hFFFFFFF3 | (($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0),
           $urandom, 5'($urandom), $urandom);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
